// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 codes, FSM states,
// access-size helpers and the default top-of-memory line index.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned LSU_MEMTOP_DEFAULT = 32'd4095;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BEAT0 = 2'b01,
        S_BEAT1 = 2'b10,
        S_RESP  = 2'b11
    } lsu_state_e;

    // Byte-lane mask of an access at offset 0; zero for codes with no size.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3)
            F3_B, F3_BU: m = 4'b0001;
            F3_H, F3_HU: m = 4'b0011;
            F3_W:        m = 4'b1111;
            default:     m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align_if.sv
// CPU-side request/response bundle of the load/store unit.
interface lsu_align_if;
    import lsu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/lsu_rdalign.sv
// Load data assembly: shifts the two-line window down to the access offset and
// sign- or zero-extends according to funct3.
module lsu_rdalign
    import lsu_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [31:0] win_s;

    // Select and extend the addressed bytes.
    always_comb begin
        win_s = 32'({hi, lo} >> {off, 3'b000});
        case (funct3)
            F3_B:    rdata = {{24{win_s[7]}}, win_s[7:0]};
            F3_H:    rdata = {{16{win_s[15]}}, win_s[15:0]};
            F3_W:    rdata = win_s;
            F3_BU:   rdata = {24'h000000, win_s[7:0]};
            F3_HU:   rdata = {16'h0000, win_s[15:0]};
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store unit between the execute stage and dmem: one access per handshake,
// split into two dmem beats when it straddles a 4-byte line.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned MEMTOP = LSU_MEMTOP_DEFAULT
)(
    input  logic        clk,
    input  logic        rst_n,
    lsu_align_if.slave  bus,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    input  logic [31:0] drdata
);

    localparam logic [31:0] MEMTOP_W = MEMTOP;

    lsu_state_e  state_r, state_nx_s;
    logic        we_r;
    logic [2:0]  f3_r;
    logic [29:0] line_r;
    logic [1:0]  off_r;
    logic [31:0] wdata_r;
    logic [3:0]  mhi_r;
    logic [31:0] lo_r;

    logic        hs_s;
    logic [29:0] req_line_s;
    logic [1:0]  req_off_s;
    logic [7:0]  req_m_s;
    logic        req_cross_s;
    logic        req_err_s;

    logic [31:0] al_hi_s, al_lo_s, align_s;
    logic [31:0] daddr_nx_s, dwdata_nx_s, rsp_rdata_nx_s;
    logic [3:0]  dwe_nx_s;
    logic        rsp_valid_nx_s, rsp_err_nx_s;

    logic [31:0] daddr_r, dwdata_r, rsp_rdata_r;
    logic [3:0]  dwe_r;
    logic        rsp_valid_r, rsp_err_r;

    assign bus.req_ready = (state_r == S_IDLE);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign daddr         = daddr_r;
    assign dwdata        = dwdata_r;
    assign dwe           = dwe_r;

    // Decode the incoming request; a crossing access also needs line+1 in range.
    always_comb begin
        hs_s        = bus.req_valid & (state_r == S_IDLE);
        req_line_s  = bus.req_addr[31:2];
        req_off_s   = bus.req_addr[1:0];
        req_m_s     = {4'b0000, size_mask(bus.req_funct3)} << req_off_s;
        req_cross_s = |req_m_s[7:4];
        req_err_s   = ~f3_legal(bus.req_we, bus.req_funct3)
                    | ({2'b00, req_line_s} > MEMTOP_W)
                    | (req_cross_s & ({2'b00, req_line_s} == MEMTOP_W));
    end

    // Load window: the second beat pairs the live word with the first beat's capture.
    always_comb begin
        if (state_r == S_BEAT1) begin
            al_hi_s = drdata;
            al_lo_s = lo_r;
        end else begin
            al_hi_s = 32'h0000_0000;
            al_lo_s = drdata;
        end
    end

    lsu_rdalign u_rdalign (
        .hi     (al_hi_s),
        .lo     (al_lo_s),
        .off    (off_r),
        .funct3 (f3_r),
        .rdata  (align_s)
    );

    // Next state and the values the output registers take on the coming edge.
    always_comb begin
        state_nx_s     = state_r;
        daddr_nx_s     = 32'h0000_0000;
        dwe_nx_s       = 4'b0000;
        dwdata_nx_s    = 32'h0000_0000;
        rsp_valid_nx_s = 1'b0;
        rsp_err_nx_s   = 1'b0;
        rsp_rdata_nx_s = 32'h0000_0000;
        case (state_r)
            S_IDLE: begin
                if (hs_s && req_err_s) begin
                    state_nx_s     = S_RESP;
                    rsp_valid_nx_s = 1'b1;
                    rsp_err_nx_s   = 1'b1;
                end else if (hs_s) begin
                    state_nx_s = S_BEAT0;
                    daddr_nx_s = {req_line_s, 2'b00};
                    if (bus.req_we) begin
                        dwe_nx_s    = req_m_s[3:0];
                        dwdata_nx_s = bus.req_wdata << {req_off_s, 3'b000};
                    end else begin
                        dwe_nx_s    = 4'b0000;
                        dwdata_nx_s = 32'h0000_0000;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_BEAT0: begin
                if (|mhi_r) begin
                    state_nx_s = S_BEAT1;
                    daddr_nx_s = {line_r + 30'd1, 2'b00};
                    if (we_r) begin
                        dwe_nx_s    = mhi_r;
                        dwdata_nx_s = wdata_r >> (6'd32 - {1'b0, off_r, 3'b000});
                    end else begin
                        dwe_nx_s    = 4'b0000;
                        dwdata_nx_s = 32'h0000_0000;
                    end
                end else begin
                    state_nx_s     = S_RESP;
                    rsp_valid_nx_s = 1'b1;
                    rsp_rdata_nx_s = we_r ? 32'h0000_0000 : align_s;
                end
            end
            S_BEAT1: begin
                state_nx_s     = S_RESP;
                rsp_valid_nx_s = 1'b1;
                rsp_rdata_nx_s = we_r ? 32'h0000_0000 : align_s;
            end
            S_RESP: begin
                state_nx_s = S_IDLE;
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Registered dmem drive and response; reset clears them immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            daddr_r     <= 32'h0000_0000;
            dwe_r       <= 4'b0000;
            dwdata_r    <= 32'h0000_0000;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            daddr_r     <= daddr_nx_s;
            dwe_r       <= dwe_nx_s;
            dwdata_r    <= dwdata_nx_s;
            rsp_valid_r <= rsp_valid_nx_s;
            rsp_err_r   <= rsp_err_nx_s;
            rsp_rdata_r <= rsp_rdata_nx_s;
        end
    end

    // Request latch at handshake and first-beat read capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            f3_r    <= 3'b000;
            line_r  <= 30'd0;
            off_r   <= 2'b00;
            wdata_r <= 32'h0000_0000;
            mhi_r   <= 4'b0000;
            lo_r    <= 32'h0000_0000;
        end else begin
            if (hs_s) begin
                we_r    <= bus.req_we;
                f3_r    <= bus.req_funct3;
                line_r  <= req_line_s;
                off_r   <= req_off_s;
                wdata_r <= bus.req_wdata;
                mhi_r   <= req_m_s[7:4];
            end
            if (state_r == S_BEAT0) begin
                lo_r <= drdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Randomized self-checking bench for lsu_align against a byte-addressed memory model.
module tb_lsu_align;
    import lsu_pkg::*;

    localparam longint MTOP = 4095;

    logic        clk;
    logic        rst_n;
    logic [31:0] daddr, dwdata, drdata;
    logic [3:0]  dwe;

    lsu_align_if bus ();

    lsu_align #(.MEMTOP(32'd4095)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .daddr  (daddr),
        .dwdata (dwdata),
        .dwe    (dwe),
        .drdata (drdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem: combinational read, byte-enable write on the clock edge
    logic [31:0] dmem [0:4095];
    logic        mem_init_done = 1'b0;
    logic        poke_en = 1'b0;
    logic [11:0] poke_line = 12'd0;
    logic [31:0] poke_data = 32'h0;

    function automatic logic [31:0] word_init(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    assign drdata = dmem[daddr[13:2]];

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 4096; i++) dmem[i] <= word_init(i);
            mem_init_done <= 1'b1;
        end else if (poke_en) begin
            dmem[poke_line] <= poke_data;
        end else begin
            for (int j = 0; j < 4; j++)
                if (dwe[j]) dmem[daddr[13:2]][8*j +: 8] <= dwdata[8*j +: 8];
        end
    end

    // Reference memory and expected per-cycle trace
    logic [7:0] ref_mem [0:16383];

    typedef struct packed {
        logic [31:0] daddr;
        logic [3:0]  dwe;
        logic [31:0] dwdata;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        pin_en;
        logic [31:0] pin_rdata;
        logic        pin_err;
        logic [1:0]  mem_n;
        logic [11:0] mline0;
        logic [11:0] mline1;
        logic [31:0] mword0;
        logic [31:0] mword1;
    } exp_t;

    exp_t exp_q [$];
    logic check_en;
    int   n_chk;
    int   n_pass;

    task automatic check(input logic ok, input string name, input string detail);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic logic [31:0] ref_word(input int ln);
        return {ref_mem[4*ln+3], ref_mem[4*ln+2], ref_mem[4*ln+1], ref_mem[4*ln]};
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic set_word(input int ln, input logic [31:0] w);
        poke_en = 1'b1; poke_line = 12'(ln); poke_data = w;
        @(posedge clk); #1;
        poke_en = 1'b0;
        for (int j = 0; j < 4; j++) ref_mem[4*ln+j] = w[8*j +: 8];
    endtask

    // Issue one request, predict its complete cycle trace from byte-level rules.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic pin_en,
                          input logic [31:0] pin_rdata, input logic pin_err);
        longint a, first, last;
        int     size, n;
        logic   legal, err;
        logic [31:0] val;
        exp_t   e;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata;
        check(bus.req_ready === 1'b1, "ready_before_req", $sformatf("got %b need 1", bus.req_ready));
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
        bus.req_funct3 = 3'($urandom); bus.req_we = 1'($urandom);

        a = longint'(addr);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        first = a >> 2;
        last = legal ? ((a + size - 1) >> 2) : first;
        err = !legal || (last > MTOP);
        if (err) begin
            e = '0; e.rv = 1'b1; e.err = 1'b1;
            e.pin_en = pin_en; e.pin_rdata = pin_rdata; e.pin_err = pin_err;
            exp_q.push_back(e);
        end else begin
            for (longint ln = first; ln <= last; ln++) begin
                e = '0; e.daddr = 32'(ln * 4);
                for (int j = 0; j < 4; j++) begin
                    longint b = ln * 4 + j;
                    if (we && b >= a && b < a + size) begin
                        e.dwe[j] = 1'b1;
                        e.dwdata[8*j +: 8] = wdata[8*int'(b - a) +: 8];
                        ref_mem[int'(b)] = wdata[8*int'(b - a) +: 8];
                    end
                end
                exp_q.push_back(e);
            end
            val = 32'h0;
            for (int i = 0; i < size; i++) val[8*i +: 8] = ref_mem[int'(a) + i];
            if (!f3[2] && size == 1) val = {{24{val[7]}}, val[7:0]};
            if (!f3[2] && size == 2) val = {{16{val[15]}}, val[15:0]};
            e = '0; e.rv = 1'b1; e.rdata = we ? 32'h0 : val;
            e.pin_en = pin_en; e.pin_rdata = pin_rdata; e.pin_err = pin_err;
            e.mem_n = (last != first) ? 2'd2 : 2'd1;
            e.mline0 = 12'(first); e.mline1 = 12'(last);
            e.mword0 = ref_word(int'(first)); e.mword1 = ref_word(int'(last));
            exp_q.push_back(e);
        end
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (exp_q.size() > 0) begin
            check(1'b0, "rsp_timeout", $sformatf("pending %0d records", exp_q.size()));
            exp_q.delete();
        end
    endtask

    // Compare DUT outputs against the next expected record every cycle.
    task automatic compare_loop();
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (check_en) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else begin e = '0; e.rdy = 1'b1; end
                ok = (daddr === e.daddr) && (dwe === e.dwe)
                  && (((dwdata ^ e.dwdata) & lanes(e.dwe)) === 32'h0)
                  && (bus.req_ready === e.rdy) && (bus.rsp_valid === e.rv)
                  && (!e.rv || (bus.rsp_rdata === e.rdata && bus.rsp_err === e.err));
                check(ok, "cycle", $sformatf(
                    "got daddr=%08h dwe=%b dwdata=%08h rdy=%b rv=%b rdata=%08h err=%b; need daddr=%08h dwe=%b dwdata=%08h rdy=%b rv=%b rdata=%08h err=%b",
                    daddr, dwe, dwdata, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                    e.daddr, e.dwe, e.dwdata, e.rdy, e.rv, e.rdata, e.err));
                if (e.rv && e.pin_en)
                    check(bus.rsp_rdata === e.pin_rdata && bus.rsp_err === e.pin_err, "literal_rsp",
                          $sformatf("got %08h/%b need %08h/%b", bus.rsp_rdata, bus.rsp_err, e.pin_rdata, e.pin_err));
                if (e.mem_n >= 2'd1)
                    check(dmem[e.mline0] === e.mword0, "mem_line0",
                          $sformatf("line %0d got %08h need %08h", e.mline0, dmem[e.mline0], e.mword0));
                if (e.mem_n == 2'd2)
                    check(dmem[e.mline1] === e.mword1, "mem_line1",
                          $sformatf("line %0d got %08h need %08h", e.mline1, dmem[e.mline1], e.mword1));
            end
        end
    endtask

    task automatic reset_abort_test();
        check_en = 1'b0;
        set_word(16, 32'hA5A5A5A5);
        set_word(17, 32'hA5A5A5A5);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
        bus.req_addr = 32'h41; bus.req_wdata = 32'h11223344;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #2;
        check(dwe === 4'b0001 && daddr === 32'h44, "beat1_drive",
              $sformatf("got dwe=%b daddr=%08h need 0001/00000044", dwe, daddr));
        rst_n = 1'b0; #1;
        check(dwe === 4'b0000 && daddr === 32'h0, "async_drop",
              $sformatf("got dwe=%b daddr=%08h need 0000/00000000", dwe, daddr));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check(bus.rsp_valid === 1'b0 && bus.req_ready === 1'b1, "after_abort",
                  $sformatf("got rv=%b rdy=%b need 0/1", bus.rsp_valid, bus.req_ready));
        end
        check(dmem[16] === 32'h223344A5, "abort_beat0_kept", $sformatf("got %08h need 223344a5", dmem[16]));
        check(dmem[17] === 32'hA5A5A5A5, "abort_beat1_none", $sformatf("got %08h need a5a5a5a5", dmem[17]));
        ref_mem[16'h41] = 8'h44; ref_mem[16'h42] = 8'h33; ref_mem[16'h43] = 8'h22;
        @(posedge clk); #1;
        exp_q.delete();
        check_en = 1'b1;
    endtask

    task automatic main_seq();
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        we;
        int          sel;
        for (int i = 0; i < 4096; i++)
            for (int j = 0; j < 4; j++) begin
                logic [31:0] w;
                w = word_init(i);
                ref_mem[4*i+j] = w[8*j +: 8];
            end
        check_en = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        rst_n = 1'b1; #1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check(bus.rsp_valid === 1'b0 && bus.rsp_rdata === 32'h0 && bus.rsp_err === 1'b0,
              "reset_rsp", $sformatf("got rv=%b rdata=%08h err=%b", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err));
        check(daddr === 32'h0 && dwe === 4'b0000 && bus.req_ready === 1'b1, "reset_dmem",
              $sformatf("got daddr=%08h dwe=%b rdy=%b", daddr, dwe, bus.req_ready));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_en = 1'b1;

        set_word(4, 32'hDEADBEEF);
        do_req(1'b0, F3_W, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
        set_word(4, 32'h80112233);
        do_req(1'b0, F3_B,  32'h13, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0);
        do_req(1'b0, F3_BU, 32'h13, 32'h0, 1'b1, 32'h00000080, 1'b0);
        do_req(1'b1, F3_W,  32'h22, 32'hAABBCCDD, 1'b1, 32'h0, 1'b0);
        do_req(1'b0, F3_W,  32'h22, 32'h0, 1'b1, 32'hAABBCCDD, 1'b0);
        do_req(1'b0, F3_W,  32'h3FFD, 32'h0, 1'b1, 32'h0, 1'b1);
        do_req(1'b0, F3_H,  32'h4000, 32'h0, 1'b1, 32'h0, 1'b1);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1);
        do_req(1'b1, F3_H,  32'h11, 32'h00001234, 1'b1, 32'h0, 1'b0);
        do_req(1'b0, F3_W,  32'h10, 32'h0, 1'b1, 32'h80123433, 1'b0);
        do_req(1'b0, F3_HU, 32'h3FFE, 32'h0, 1'b0, 32'h0, 1'b0);
        do_req(1'b1, F3_BU, 32'h20, 32'h55, 1'b1, 32'h0, 1'b1);

        reset_abort_test();

        for (int t = 0; t < 400; t++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      addr = $urandom_range(0, 255);
            else if (sel == 7) addr = $urandom_range(32'h3FF0, 32'h3FFF);
            else if (sel == 8) addr = $urandom_range(32'h4000, 32'h4010);
            else               addr = $urandom;
            we = 1'($urandom);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = F3_B;
                    1: f3 = F3_H;
                    2: f3 = F3_W;
                    3: f3 = F3_BU;
                    default: f3 = F3_HU;
                endcase
            end
            do_req(we, f3, addr, $urandom, 1'b0, 32'h0, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        fork
            compare_loop();
            main_seq();
        join_any
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
